// File: rtl/mem_reset_sequencer.sv
// Multi-channel DDR reset sequencer: synchronises board clock-good / system reset,
// holds each controller in reset, then supervises calibration with bounded retries.
module mem_reset_sequencer #(
   parameter int NUM_CH        = 2,
   parameter int SYNC_STAGES   = 3,
   parameter int HOLD_CYCLES   = 16,
   parameter int CALIB_TIMEOUT = 1048576,
   parameter int MAX_RETRIES   = 3
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              clock_ok,
   input  logic              sys_reset,
   input  logic [NUM_CH-1:0] mmcm_locked,
   input  logic [NUM_CH-1:0] calib_complete,
   input  logic [NUM_CH-1:0] ui_clk_sync_rst,
   output logic [NUM_CH-1:0] mem_reset,
   output logic [NUM_CH-1:0] aresetn,
   output logic [NUM_CH-1:0] mem_ok,
   output logic [NUM_CH-1:0] mem_fail,
   output logic              all_mem_ok
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int CW = $clog2(CALIB_TIMEOUT);
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

   typedef enum logic [1:0] {
      ST_HOLD       = 2'd0,
      ST_WAIT_CALIB = 2'd1,
      ST_RUN        = 2'd2,
      ST_FAILED     = 2'd3
   } state_t;

   // Both asynchronous inputs are brought in through their own flop chains.
   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ok_sync_q;
   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] nrst_sync_q;
   logic [SYNC_STAGES-1:0] ok_sync_d;
   logic [SYNC_STAGES-1:0] nrst_sync_d;
   logic                   sync_ok;

   always_comb begin
      ok_sync_d   = {ok_sync_q[SYNC_STAGES-2:0], clock_ok};
      nrst_sync_d = {nrst_sync_q[SYNC_STAGES-2:0], ~sys_reset};
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         ok_sync_q   <= '0;
         nrst_sync_q <= '0;
      end else begin
         ok_sync_q   <= ok_sync_d;
         nrst_sync_q <= nrst_sync_d;
      end
   end

   assign sync_ok = ok_sync_q[SYNC_STAGES-1] & nrst_sync_q[SYNC_STAGES-1];

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t        state_q, state_d;
      logic [HW-1:0] hold_cnt_q, hold_cnt_d;
      logic [CW-1:0] calib_timer_q, calib_timer_d;
      logic [RW-1:0] retry_cnt_q, retry_cnt_d;
      logic          mem_reset_q, mem_reset_d;
      logic          mem_fail_q, mem_fail_d;
      logic          ready;

      assign ready = mmcm_locked[gi] & calib_complete[gi] & ~ui_clk_sync_rst[gi];

      always_comb begin
         state_d       = state_q;
         hold_cnt_d    = hold_cnt_q;
         calib_timer_d = calib_timer_q;
         retry_cnt_d   = retry_cnt_q;
         if (!sync_ok) begin
            state_d       = ST_HOLD;
            hold_cnt_d    = '0;
            calib_timer_d = '0;
            retry_cnt_d   = '0;
         end else begin
            case (state_q)
               ST_HOLD: begin
                  if (hold_cnt_q == HOLD_LAST) begin
                     state_d       = ST_WAIT_CALIB;
                     hold_cnt_d    = '0;
                     calib_timer_d = '0;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HW'(1);
                  end
               end
               ST_WAIT_CALIB: begin
                  // A ready seen on the timeout cycle still counts as success.
                  if (ready) begin
                     state_d     = ST_RUN;
                     retry_cnt_d = '0;
                  end else if (calib_timer_q == CALIB_LAST) begin
                     if (retry_cnt_q < RETRY_MAX) begin
                        state_d     = ST_HOLD;
                        hold_cnt_d  = '0;
                        retry_cnt_d = retry_cnt_q + RW'(1);
                     end else begin
                        state_d = ST_FAILED;
                     end
                  end else begin
                     calib_timer_d = calib_timer_q + CW'(1);
                  end
               end
               ST_RUN: begin
                  if (!ready) begin
                     state_d       = ST_WAIT_CALIB;
                     calib_timer_d = '0;
                  end
               end
               ST_FAILED: begin
                  state_d = ST_FAILED;
               end
               default: begin
                  state_d = ST_HOLD;
               end
            endcase
         end
         // Registered decode of the next state keeps these outputs glitch-free.
         mem_reset_d = (state_d == ST_HOLD) || (state_d == ST_FAILED);
         mem_fail_d  = (state_d == ST_FAILED);
      end

      always_ff @(posedge clock) begin
         if (!resetn) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            calib_timer_q <= '0;
            retry_cnt_q   <= '0;
            mem_reset_q   <= 1'b1;
            mem_fail_q    <= 1'b0;
         end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            calib_timer_q <= calib_timer_d;
            retry_cnt_q   <= retry_cnt_d;
            mem_reset_q   <= mem_reset_d;
            mem_fail_q    <= mem_fail_d;
         end
      end

      assign mem_reset[gi] = mem_reset_q;
      assign mem_fail[gi]  = mem_fail_q;
      assign mem_ok[gi]    = (state_q == ST_RUN) & ready;
      assign aresetn[gi]   = ~ui_clk_sync_rst[gi] & ~mem_reset_q;
   end

   assign all_mem_ok = &mem_ok;

endmodule

// File: tb/tb_mem_reset_sequencer.sv
module tb_mem_reset_sequencer;

   logic       clock = 1'b0;
   logic       resetn;
   logic       clock_ok;
   logic       sys_reset;
   logic [1:0] mmcm_locked;
   logic [1:0] calib_complete;
   logic [1:0] ui_clk_sync_rst;
   logic [1:0] mem_reset;
   logic [1:0] aresetn;
   logic [1:0] mem_ok;
   logic [1:0] mem_fail;
   logic       all_mem_ok;

   mem_reset_sequencer #(
      .NUM_CH        (2),
      .SYNC_STAGES   (3),
      .HOLD_CYCLES   (16),
      .CALIB_TIMEOUT (64),
      .MAX_RETRIES   (2)
   ) dut (
      .clock           (clock),
      .resetn          (resetn),
      .clock_ok        (clock_ok),
      .sys_reset       (sys_reset),
      .mmcm_locked     (mmcm_locked),
      .calib_complete  (calib_complete),
      .ui_clk_sync_rst (ui_clk_sync_rst),
      .mem_reset       (mem_reset),
      .aresetn         (aresetn),
      .mem_ok          (mem_ok),
      .mem_fail        (mem_fail),
      .all_mem_ok      (all_mem_ok)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      string      name;
      logic [1:0] mr;
      logic [1:0] ar;
      logic [1:0] ok;
      logic [1:0] fl;
      logic       al;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   kcnt     = 0;

   task automatic step();
      @(posedge clock);
      #1;
      kcnt++;
   endtask

   task automatic wait_k(input int target);
      while (kcnt < target) step();
   endtask

   task automatic chk(input string name, input logic [1:0] mr, input logic [1:0] ar,
                      input logic [1:0] ok, input logic [1:0] fl, input logic al);
      exp_t e;
      e.cyc  = cyc;
      e.name = name;
      e.mr   = mr;
      e.ar   = ar;
      e.ok   = ok;
      e.fl   = fl;
      e.al   = al;
      sb_q.push_back(e);
   endtask

   initial begin
      exp_t       e;
      logic [8:0] got;
      logic [8:0] want;
      forever begin
         @(negedge clock);
         while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e    = sb_q.pop_front();
            got  = {mem_reset, aresetn, mem_ok, mem_fail, all_mem_ok};
            want = {e.mr, e.ar, e.ok, e.fl, e.al};
            checks++;
            if (e.cyc != cyc || got !== want) begin
               failures++;
               $display("FAIL %s cyc=%0d(due %0d) got mr=%b ar=%b ok=%b fail=%b all=%b want mr=%b ar=%b ok=%b fail=%b all=%b",
                        e.name, cyc, e.cyc, mem_reset, aresetn, mem_ok, mem_fail, all_mem_ok,
                        e.mr, e.ar, e.ok, e.fl, e.al);
            end else begin
               $display("ok   %s cyc=%0d mr=%b ar=%b ok=%b fail=%b all=%b",
                        e.name, cyc, mem_reset, aresetn, mem_ok, mem_fail, all_mem_ok);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d limit reached, required finish before it", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      resetn          = 1'b0;
      clock_ok        = 1'b1;
      sys_reset       = 1'b0;
      mmcm_locked     = 2'b00;
      calib_complete  = 2'b00;
      ui_clk_sync_rst = 2'b00;

      repeat (3) step();
      chk("in_reset", 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      checks++;
      if (mem_reset !== 2'b11 || aresetn !== 2'b00) begin
         failures++;
         $display("FAIL direct_in_reset cyc=%0d mr=%b ar=%b want mr=11 ar=00", cyc, mem_reset, aresetn);
      end else begin
         $display("ok   direct_in_reset cyc=%0d mr=%b ar=%b", cyc, mem_reset, aresetn);
      end
      repeat (2) step();
      resetn = 1'b1;
      kcnt   = 0;
      wait_k(1);   chk("hold_start",    2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      wait_k(18);  chk("hold_last",     2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      wait_k(19);  chk("mr_fall",       2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
      mmcm_locked = 2'b11;

      wait_k(29);  calib_complete = 2'b11;
      chk("calib_seen",    2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
      wait_k(30);  chk("both_run",      2'b00, 2'b11, 2'b11, 2'b00, 1'b1);

      wait_k(35);  calib_complete = 2'b01;
      chk("ch1_drop",      2'b00, 2'b11, 2'b01, 2'b00, 1'b0);
      wait_k(99);  chk("wait1_last",    2'b00, 2'b11, 2'b01, 2'b00, 1'b0);
      wait_k(100); chk("retry1_hold",   2'b10, 2'b01, 2'b01, 2'b00, 1'b0);
      wait_k(115); chk("retry1_hlast",  2'b10, 2'b01, 2'b01, 2'b00, 1'b0);
      wait_k(116); chk("retry1_wait",   2'b00, 2'b11, 2'b01, 2'b00, 1'b0);
      wait_k(180); chk("retry2_hold",   2'b10, 2'b01, 2'b01, 2'b00, 1'b0);
      wait_k(196); chk("retry2_wait",   2'b00, 2'b11, 2'b01, 2'b00, 1'b0);
      wait_k(259); chk("wait3_last",    2'b00, 2'b11, 2'b01, 2'b00, 1'b0);
      wait_k(260); chk("ch1_failed",    2'b10, 2'b01, 2'b01, 2'b10, 1'b0);
      wait_k(280); chk("ch1_stays",     2'b10, 2'b01, 2'b01, 2'b10, 1'b0);

      wait_k(290); sys_reset = 1'b1;
      wait_k(292); sys_reset = 1'b0;
      wait_k(293); chk("abort_pending", 2'b10, 2'b01, 2'b01, 2'b10, 1'b0);
      wait_k(294); chk("abort_hold",    2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      wait_k(310); chk("rec_hlast",     2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      wait_k(311); chk("rec_fall",      2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
      wait_k(312); chk("rec_ch0_run",   2'b00, 2'b11, 2'b01, 2'b00, 1'b0);
      wait_k(374); chk("rec_wait_last", 2'b00, 2'b11, 2'b01, 2'b00, 1'b0);
      wait_k(375); chk("rec_retry",     2'b10, 2'b01, 2'b01, 2'b00, 1'b0);
      wait_k(376); calib_complete = 2'b11;
      wait_k(391); chk("rec_ch1_wait",  2'b00, 2'b11, 2'b01, 2'b00, 1'b0);
      wait_k(392); chk("rec_both_run",  2'b00, 2'b11, 2'b11, 2'b00, 1'b1);

      wait_k(400); calib_complete = 2'b10;
      chk("loss_cycle",    2'b00, 2'b11, 2'b10, 2'b00, 1'b0);
      wait_k(401); calib_complete = 2'b11;
      chk("loss_wait",     2'b00, 2'b11, 2'b10, 2'b00, 1'b0);
      wait_k(402); chk("loss_back",     2'b00, 2'b11, 2'b11, 2'b00, 1'b1);

      wait_k(410); clock_ok = 1'b0;
      wait_k(411); clock_ok = 1'b1;
      wait_k(413); chk("glitch_pend",   2'b00, 2'b11, 2'b11, 2'b00, 1'b1);
      wait_k(414); chk("glitch_hold",   2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      wait_k(426); clock_ok = 1'b0;
      wait_k(427); clock_ok = 1'b1;
      wait_k(430); chk("abort_at_15",   2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      wait_k(445); chk("rehold_last",   2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      wait_k(446); chk("rehold_fall",   2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
      wait_k(447); chk("rehold_run",    2'b00, 2'b11, 2'b11, 2'b00, 1'b1);

      wait_k(450); calib_complete = 2'b00;
      chk("tmo_drop",      2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
      wait_k(514); calib_complete = 2'b11;
      chk("tmo_edge",      2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
      wait_k(515); chk("tmo_ready_wins",2'b00, 2'b11, 2'b11, 2'b00, 1'b1);
      wait_k(530); chk("tmo_stay_run",  2'b00, 2'b11, 2'b11, 2'b00, 1'b1);

      wait_k(540); ui_clk_sync_rst = 2'b01;
      chk("ui_rst",        2'b00, 2'b10, 2'b10, 2'b00, 1'b0);
      wait_k(541); ui_clk_sync_rst = 2'b00;
      chk("ui_rst_wait",   2'b00, 2'b11, 2'b10, 2'b00, 1'b0);
      wait_k(542); chk("ui_rst_back",   2'b00, 2'b11, 2'b11, 2'b00, 1'b1);

      repeat (3) step();
      checks++;
      if (mem_ok !== 2'b11 || all_mem_ok !== 1'b1 || mem_fail !== 2'b00 || mem_reset !== 2'b00) begin
         failures++;
         $display("FAIL direct_final cyc=%0d mr=%b ok=%b fail=%b all=%b want mr=00 ok=11 fail=00 all=1",
                  cyc, mem_reset, mem_ok, mem_fail, all_mem_ok);
      end else begin
         $display("ok   direct_final cyc=%0d mr=%b ok=%b fail=%b all=%b",
                  cyc, mem_reset, mem_ok, mem_fail, all_mem_ok);
      end
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         failures++;
         $display("FAIL %s never compared: due cyc=%0d, now cyc=%0d", e.name, e.cyc, cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
